// File: rtl/channel_sim_pkg.sv
// Shared constants for the channel simulator: noise LFSR seed/taps and the
// guard bits used when summing the direct, echo and noise terms.
package channel_sim_pkg;

  // 16-bit Galois LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LfsrSeed  = 16'hACE1;
  localparam logic [15:0] LfsrTaps  = 16'hB400;

  // Extra sum bits so direct + echo + noise never overflows before clipping
  localparam int unsigned GuardBits = 2;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ LfsrTaps) : (state >> 1);
  endfunction

endpackage

// File: rtl/channel_delay_line.sv
// Circular sample history for the echo path. Writes advance the pointer,
// reads look back rd_offset samples; offset 0 returns the sample being written.
module channel_delay_line #(
  parameter int unsigned Width = 12,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [Width-1:0]         wr_data,
  input  logic [$clog2(Depth)-1:0] rd_offset,
  output logic [Width-1:0]         rd_data
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rd_idx;

  // Write the new sample and bump the pointer; Depth is a power of two so it wraps
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    if (wr_en) begin
      mem_d[wptr_q] = wr_data;
      wptr_d        = wptr_q + 1'b1;
    end
  end

  // History is cleared on reset so unwritten entries read back as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      mem_q  <= mem_d;
    end
  end

  // Look back from the write slot; offset 0 bypasses to the incoming sample
  always_comb begin
    rd_idx  = wptr_q - rd_offset;
    rd_data = (rd_offset == '0) ? wr_data : mem_q[rd_idx];
  end

endmodule

// File: rtl/channel_sim_mp.sv
// Two-stage channel model: attenuated direct path plus optional delayed echo
// and optional LFSR noise, summed with guard bits and clipped to the sample range.
// Additive noise is compiled in only when CHANNEL_SIM_NOISE_EN is defined.
module channel_sim_mp
  import channel_sim_pkg::*;
#(
  parameter int AD_CVER_WIDTH = 12,
  parameter int MAX_DELAY     = 16,
  parameter int NOISE_W       = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            din_valid,
  input  logic signed [AD_CVER_WIDTH-1:0] data_in,
  input  logic [3:0]                      cfg_att_shift,
  input  logic                            cfg_echo_en,
  input  logic [3:0]                      cfg_echo_shift,
  input  logic [$clog2(MAX_DELAY)-1:0]    cfg_delay,
  output logic                            dout_valid,
  output logic signed [AD_CVER_WIDTH-1:0] data_out,
  output logic                            sat_flag
);

  localparam int W      = AD_CVER_WIDTH;
  localparam int SumW   = W + int'(GuardBits);
  localparam int MaxVal = (1 << (W - 1)) - 1;
  localparam int MinVal = -(1 << (W - 1));
  localparam logic signed [SumW-1:0] SumMax = SumW'(MaxVal);
  localparam logic signed [SumW-1:0] SumMin = SumW'(MinVal);

  // Shifts past W-2 already leave only the sign, so clamp them explicitly
  function automatic logic signed [W-1:0] sat_shift(input logic signed [W-1:0] x,
                                                    input logic [3:0] sh);
    if (32'(sh) >= 32'(W - 1)) begin
      return {W{x[W-1]}};
    end
    return x >>> sh;
  endfunction

  logic signed [W-1:0]    echo_raw;
  logic signed [SumW-1:0] noise_term;

  channel_delay_line #(
    .Width (W),
    .Depth (MAX_DELAY)
  ) u_delay_line (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (din_valid),
    .wr_data   (data_in),
    .rd_offset (cfg_delay),
    .rd_data   (echo_raw)
  );

`ifdef CHANNEL_SIM_NOISE_EN
  logic [15:0]              lfsr_q, lfsr_d;
  logic signed [NOISE_W-1:0] noise_raw;

  // Noise source steps once per accepted sample
  always_comb begin
    lfsr_d = lfsr_q;
    if (din_valid) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR state register, reseeded on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign noise_raw  = lfsr_q[NOISE_W-1:0];
  assign noise_term = SumW'(noise_raw);
`else
  assign noise_term = '0;
`endif

  // Stage 1: capture shifted terms with the configuration seen on the accepted cycle
  logic                   v1_q, v1_d;
  logic signed [W-1:0]    direct_q, direct_d;
  logic signed [W-1:0]    echo_q, echo_d;
  logic signed [SumW-1:0] noise_q, noise_d;

  // Stage-1 next state: only accepted samples load new terms
  always_comb begin
    v1_d     = din_valid;
    direct_d = direct_q;
    echo_d   = echo_q;
    noise_d  = noise_q;
    if (din_valid) begin
      direct_d = sat_shift(data_in, cfg_att_shift);
      echo_d   = cfg_echo_en ? sat_shift(echo_raw, cfg_echo_shift) : '0;
      noise_d  = noise_term;
    end
  end

  // Stage-1 registers
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      direct_q <= '0;
      echo_q   <= '0;
      noise_q  <= '0;
    end else begin
      v1_q     <= v1_d;
      direct_q <= direct_d;
      echo_q   <= echo_d;
      noise_q  <= noise_d;
    end
  end

  // Stage 2: wide sum, clip, and hold the last result between valid outputs
  logic                   v2_q, v2_d;
  logic signed [W-1:0]    out_q, out_d;
  logic                   sat_q, sat_d;
  logic signed [SumW-1:0] sum;
  logic signed [W-1:0]    clipped;
  logic                   clip;

  // Stage-2 next state: saturate the sum and flag any clipping
  always_comb begin
    sum     = SumW'(direct_q) + SumW'(echo_q) + noise_q;
    clipped = sum[W-1:0];
    clip    = 1'b0;
    if (sum > SumMax) begin
      clipped = W'(MaxVal);
      clip    = 1'b1;
    end else if (sum < SumMin) begin
      clipped = W'(MinVal);
      clip    = 1'b1;
    end
    v2_d  = v1_q;
    out_d = out_q;
    sat_d = sat_q;
    if (v1_q) begin
      out_d = clipped;
      sat_d = clip;
    end
  end

  // Stage-2 registers drive the outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q  <= 1'b0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      v2_q  <= v2_d;
      out_q <= out_d;
      sat_q <= sat_d;
    end
  end

  assign dout_valid = v2_q;
  assign data_out   = out_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_channel_sim_mp.sv
// Self-checking bench for channel_sim_mp: vector table, hand-written corner
// sequences and randomized traffic against a sample-history reference model.
module tb_channel_sim_mp;

  localparam int W  = 12;
  localparam int MD = 16;
  localparam int NW = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                din_valid = 1'b0;
  logic signed [W-1:0] data_in = '0;
  logic [3:0]          cfg_att_shift = '0;
  logic                cfg_echo_en = 1'b0;
  logic [3:0]          cfg_echo_shift = '0;
  logic [3:0]          cfg_delay = '0;
  logic                dout_valid;
  logic signed [W-1:0] data_out;
  logic                sat_flag;

  channel_sim_mp #(
    .AD_CVER_WIDTH (W),
    .MAX_DELAY     (MD),
    .NOISE_W       (NW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .din_valid      (din_valid),
    .data_in        (data_in),
    .cfg_att_shift  (cfg_att_shift),
    .cfg_echo_en    (cfg_echo_en),
    .cfg_echo_shift (cfg_echo_shift),
    .cfg_delay      (cfg_delay),
    .dout_valid     (dout_valid),
    .data_out       (data_out),
    .sat_flag       (sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit sat;
    int due;
  } exp_t;

  exp_t        expq[$];
  int          hist[$];
  int          obs[$];
  logic [15:0] m_lfsr = 16'hACE1;
  int          last_out = 0;
  bit          last_sat = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Arithmetic shift on a 32-bit int; large shifts naturally leave only the sign
  function automatic int shr(input int x, input int s);
    return x >>> s;
  endfunction

  task automatic model_reset();
    hist.delete();
    expq.delete();
    m_lfsr   = 16'hACE1;
    last_out = 0;
    last_sat = 1'b0;
  endtask

  // Expected output of one accepted sample from the channel equation
  task automatic model_accept(input int x);
    int e = 0;
    int n = 0;
    int d = int'(cfg_delay);
    int y;
    bit s = 1'b0;
    hist.push_back(x);
    if (hist.size() > MD) void'(hist.pop_front());
    if (cfg_echo_en && hist.size() > d) e = shr(hist[hist.size() - 1 - d], int'(cfg_echo_shift));
`ifdef CHANNEL_SIM_NOISE_EN
    n = int'(m_lfsr[NW-1:0]);
    if (n >= (1 << (NW - 1))) n -= (1 << NW);
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
    y = shr(x, int'(cfg_att_shift)) + e + n;
    if (y > 2047) begin
      y = 2047;
      s = 1'b1;
    end else if (y < -2048) begin
      y = -2048;
      s = 1'b1;
    end
    expq.push_back('{data: y, sat: s, due: cyc + 1});
  endtask

  // Cycle-accurate monitor: every cycle is either the due output or an idle hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        check("dout_valid", int'(dout_valid), 1);
        check("data_out", int'(data_out), expq[0].data);
        check("sat_flag", int'(sat_flag), int'(expq[0].sat));
        last_out = expq[0].data;
        last_sat = expq[0].sat;
        void'(expq.pop_front());
      end else begin
        check("idle_valid", int'(dout_valid), 0);
        check("hold_data", int'(data_out), last_out);
        check("hold_sat", int'(sat_flag), int'(last_sat));
      end
      if (dout_valid) obs.push_back(int'(data_out));
    end
  end

  task automatic step(input bit r, input bit v, input int x);
    rst       = r;
    din_valid = v;
    data_in   = W'(x);
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (v) model_accept(x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0);
  endtask

  task automatic set_cfg(input int att, input bit en, input int esh, input int d);
    cfg_att_shift  = 4'(att);
    cfg_echo_en    = en;
    cfg_echo_shift = 4'(esh);
    cfg_delay      = 4'(d);
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  typedef struct {
    int att;
    bit en;
    int esh;
    int d;
    int x;
    int y;
    bit s;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1,  1'b0, 0,  0, 1024,  512,   1'b0};
    tbl[1]  = '{1,  1'b0, 0,  0, -7,    -4,    1'b0};
    tbl[2]  = '{0,  1'b1, 0,  0, 2047,  2047,  1'b1};
    tbl[3]  = '{0,  1'b1, 0,  0, -2048, -2048, 1'b1};
    tbl[4]  = '{0,  1'b0, 0,  0, 100,   100,   1'b0};
    tbl[5]  = '{2,  1'b0, 0,  0, -100,  -25,   1'b0};
    tbl[6]  = '{11, 1'b0, 0,  0, -5,    -1,    1'b0};
    tbl[7]  = '{15, 1'b0, 0,  0, 5,     0,     1'b0};
    tbl[8]  = '{0,  1'b1, 1,  0, 1000,  1500,  1'b0};
    tbl[9]  = '{1,  1'b1, 0,  0, 2000,  2047,  1'b1};
    tbl[10] = '{3,  1'b0, 0,  0, -1,    -1,    1'b0};
    tbl[11] = '{0,  1'b1, 15, 0, -3,    -4,    1'b0};

    step(1'b1, 1'b0, 0);
    mon_en = 1'b1;

`ifndef CHANNEL_SIM_NOISE_EN
    // Single-sample vectors, each from a clean reset
    foreach (tbl[i]) begin
      step(1'b1, 1'b0, 0);
      set_cfg(tbl[i].att, tbl[i].en, tbl[i].esh, tbl[i].d);
      step(1'b0, 1'b1, tbl[i].x);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), int'(dout_valid), 1);
      check($sformatf("vec%0d_data", i), int'(data_out), tbl[i].y);
      check($sformatf("vec%0d_sat", i), int'(sat_flag), int'(tbl[i].s));
    end

    // Legacy >>>1 channel, back-to-back samples
    step(1'b1, 1'b0, 0);
    set_cfg(1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1024);
    step(1'b0, 1'b1, -7);
    din_valid = 1'b0;
    @(negedge clk);
    check("legacy0_valid", int'(dout_valid), 1);
    check("legacy0_data", int'(data_out), 512);
    @(negedge clk);
    check("legacy1_valid", int'(dout_valid), 1);
    check("legacy1_data", int'(data_out), -4);
    idle(2);

    // Echo impulse at delay 5 with the direct path fully attenuated
    step(1'b1, 1'b0, 0);
    obs.delete();
    set_cfg(15, 1'b1, 1, 5);
    step(1'b0, 1'b1, 1000);
    repeat (9) step(1'b0, 1'b1, 0);
    idle(3);
    check("echo_count", obs.size(), 10);
    for (int i = 0; i < obs.size(); i++) begin
      check($sformatf("echo_out%0d", i), obs[i], (i == 5) ? 500 : 0);
    end
`endif

    // Delay 15 across pointer wrap with random valid gaps
    step(1'b1, 1'b0, 0);
    obs.delete();
    set_cfg(int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 3)), 15);
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, rand_sample());
      step(1'b0, 1'b1, rand_sample());
    end
    idle(3);
    check("wrap_count", obs.size(), 40);

    // Random traffic with configuration changing every cycle
    for (int k = 0; k < 300; k++) begin
      set_cfg(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      step(1'b0, ($urandom_range(0, 9) < 7), rand_sample());
    end
    idle(3);

    // Reset with samples in flight; din_valid during reset is ignored
    step(1'b1, 1'b0, 0);
    set_cfg(0, 1'b1, 0, 1);
    obs.delete();
    step(1'b0, 1'b1, 300);
    step(1'b1, 1'b1, 400);
    step(1'b0, 1'b1, 50);
    idle(3);
    check("rst_count", obs.size(), 1);
`ifndef CHANNEL_SIM_NOISE_EN
    if (obs.size() > 0) check("rst_first_echo", obs[0], 50);
`endif

`ifdef CHANNEL_SIM_NOISE_EN
    // Zero input exposes the raw noise sequence
    begin
      logic [15:0] l;
      int          n;
      step(1'b1, 1'b0, 0);
      set_cfg(0, 1'b0, 0, 0);
      obs.delete();
      repeat (8) step(1'b0, 1'b1, 0);
      idle(3);
      check("noise_count", obs.size(), 8);
      l = 16'hACE1;
      for (int i = 0; i < 8 && i < obs.size(); i++) begin
        n = int'(l[NW-1:0]);
        if (n >= (1 << (NW - 1))) n -= (1 << NW);
        check($sformatf("noise%0d", i), obs[i], n);
        l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
      end
    end
`endif

    check("drain", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
